// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 bus bundle between the burst initiator and the interconnect.
interface wb_b3_burst_master_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic [SW-1:0] sel;
   logic          we;
   logic          cyc;
   logic          stb;
   logic [2:0]    cti;
   logic [1:0]    bte;
   logic          ack;
   logic          err;
   logic          rty;

   modport master (
      output adr, dat_w, sel, we, cyc, stb, cti, bte,
      input  dat_r, ack, err, rty
   );

   modport slave (
      input  adr, dat_w, sel, we, cyc, stb, cti, bte,
      output dat_r, ack, err, rty
   );
endinterface

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 incrementing-burst initiator fed by a command/data stream.
// Optional response watchdog: define WB_B3_BURST_MASTER_TIMEOUT_EN.
module wb_b3_burst_master #(
   parameter int unsigned MAX_LEN_W      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [31:0]          cmd_adr_i,
   input  logic [MAX_LEN_W-1:0] cmd_len_i,
   input  logic [3:0]           cmd_sel_i,
   input  logic [31:0]          wdat_i,
   input  logic                 wdat_valid_i,
   output logic                 wdat_ready_o,
   output logic [31:0]          rdat_o,
   output logic                 rdat_valid_o,
   output logic                 done_o,
   output logic                 err_o,
   wb_b3_burst_master_if.master wbm
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam logic [2:0]  CTI_INC    = 3'b010;
   localparam logic [2:0]  CTI_END    = 3'b111;
   localparam logic [1:0]  BTE_LINEAR = 2'b00;
   localparam logic [AW-1:0] ADR_STEP = AW'(4);
   localparam logic [AW-1:0] ADR_MASK = ~AW'(3);

   if (MAX_LEN_W == 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
      $error("wb_b3_burst_master: MAX_LEN_W and TIMEOUT_CYCLES must be non-zero");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RETRY, S_END} state_t;
   state_t state, state_n;

   logic [AW-1:0]        adr_q, adr_d;
   logic [DW-1:0]        dat_q, dat_d;
   logic [SW-1:0]        sel_q, sel_d;
   logic                 we_q, we_d;
   logic                 cyc_q, cyc_d;
   logic                 stb_q, stb_d;
   logic [2:0]           cti_q, cti_d;
   logic [MAX_LEN_W-1:0] len_q, len_d;
   logic [MAX_LEN_W-1:0] cnt_q, cnt_d;
   logic                 hold_q, hold_d;
   logic [DW-1:0]        rdat_q, rdat_d;
   logic                 rdat_valid_q, rdat_valid_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 cmd_ready_q, cmd_ready_d;

   logic                 accept;
   logic                 resp_ack, resp_err, resp_rty;
   logic                 last_beat;
   logic [MAX_LEN_W-1:0] cnt_inc;
   logic                 wdat_ready_c;
   logic                 wdat_take;
   logic                 hold_after;
   logic                 timeout_hit;

   // Response decode; only meaningful while a beat is strobed, err > rty > ack.
   always_comb begin
      resp_err     = stb_q & wbm.err;
      resp_rty     = stb_q & wbm.rty & ~wbm.err;
      resp_ack     = stb_q & wbm.ack & ~wbm.err & ~wbm.rty;
      accept       = cmd_valid_i & cmd_ready_q;
      last_beat    = (cnt_q == len_q);
      cnt_inc      = cnt_q + MAX_LEN_W'(1);
      wdat_ready_c = (state == S_BUS) & we_q & (~hold_q | (resp_ack & ~last_beat));
      wdat_take    = wdat_ready_c & wdat_valid_i;
      hold_after   = wdat_take | (hold_q & ~resp_ack);
   end

`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            any_resp;

   assign any_resp    = wbm.ack | wbm.err | wbm.rty;
   assign timeout_hit = stb_q & ~any_resp & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts strobed cycles without any response.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !stb_q || any_resp || timeout_hit) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (accept) state_n = S_BUS;
         S_BUS: begin
            if (resp_err || timeout_hit)    state_n = S_END;
            else if (resp_rty)              state_n = S_RETRY;
            else if (resp_ack && last_beat) state_n = S_END;
         end
         S_RETRY: state_n = S_BUS;
         S_END:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Output/datapath next values; every bus output is registered below.
   always_comb begin
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      we_d         = we_q;
      cti_d        = cti_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      rdat_d       = rdat_q;
      cyc_d        = 1'b0;
      stb_d        = 1'b0;
      rdat_valid_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      cmd_ready_d  = (state_n == S_IDLE);

      case (state)
         S_IDLE: begin
            if (accept) begin
               we_d   = cmd_we_i;
               adr_d  = cmd_adr_i & ADR_MASK;
               sel_d  = cmd_sel_i;
               len_d  = cmd_len_i;
               cnt_d  = '0;
               hold_d = 1'b0;
               cyc_d  = 1'b1;
               stb_d  = ~cmd_we_i;
               cti_d  = (cmd_len_i == '0) ? CTI_END : CTI_INC;
            end
         end
         S_BUS: begin
            if (wdat_take) dat_d = wdat_i;
            hold_d = hold_after;
            if (resp_err || timeout_hit) begin
               // Abort: remaining beats and any held word are dropped.
               done_d = 1'b1;
               err_d  = 1'b1;
               hold_d = 1'b0;
            end else if (resp_rty) begin
               // One idle cycle with cyc low; address and held data are kept.
               hold_d = hold_q;
            end else if (resp_ack) begin
               adr_d = adr_q + ADR_STEP;
               cnt_d = cnt_inc;
               if (!we_q) begin
                  rdat_d       = wbm.dat_r;
                  rdat_valid_d = 1'b1;
               end
               if (last_beat) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  cyc_d = 1'b1;
                  stb_d = ~we_q | hold_after;
                  cti_d = (cnt_inc == len_q) ? CTI_END : CTI_INC;
               end
            end else begin
               cyc_d = 1'b1;
               stb_d = ~we_q | hold_after;
            end
         end
         S_RETRY: begin
            cyc_d = 1'b1;
            stb_d = ~we_q | hold_q;
         end
         S_END: begin
            hold_d = 1'b0;
         end
         default: begin
            hold_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         we_q         <= 1'b0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         cti_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         hold_q       <= 1'b0;
         rdat_q       <= '0;
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cmd_ready_q  <= 1'b0;
      end else begin
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         cti_q        <= cti_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         rdat_q       <= rdat_d;
         rdat_valid_q <= rdat_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign wbm.adr      = adr_q;
   assign wbm.dat_w    = dat_q;
   assign wbm.sel      = sel_q;
   assign wbm.we       = we_q;
   assign wbm.cyc      = cyc_q;
   assign wbm.stb      = stb_q;
   assign wbm.cti      = cti_q;
   assign wbm.bte      = BTE_LINEAR;

   assign cmd_ready_o  = cmd_ready_q;
   assign wdat_ready_o = wdat_ready_c;
   assign rdat_o       = rdat_q;
   assign rdat_valid_o = rdat_valid_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed self-checking bench for wb_b3_burst_master with a behavioural RAM responder.
module tb_wb_b3_burst_master;
   localparam int unsigned MAX_LEN_W      = 4;
   localparam int unsigned TIMEOUT_CYCLES = 16;
   localparam logic [2:0]  CTI_INC = 3'b010;
   localparam logic [2:0]  CTI_END = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [3:0]  cmd_len;
   logic [3:0]  cmd_sel;
   logic [31:0] wdat;
   logic        wdat_valid, wdat_ready;
   logic [31:0] rdat;
   logic        rdat_valid, done, err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wb_b3_burst_master_if bus();

   wb_b3_burst_master #(.MAX_LEN_W(MAX_LEN_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_sel_i(cmd_sel),
      .wdat_i(wdat), .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready),
      .rdat_o(rdat), .rdat_valid_o(rdat_valid), .done_o(done), .err_o(err),
      .wbm(bus)
   );

   // RAM responder: unwritten words read as 0xA0000000 + word index.
   bit          wr_valid [0:1023];
   logic [31:0] wmem     [0:1023];
   logic        slave_en = 1'b1;
   logic        rty_arm = 1'b0, err_arm = 1'b0;
   logic [31:0] rty_adr = '0, err_adr = '0;
   int          rty_base = 0;
   int          rty_hits = 0;
   logic [9:0]  widx;

   always_comb begin
      widx      = bus.adr[11:2];
      bus.err   = bus.cyc & bus.stb & err_arm & (bus.adr == err_adr);
      bus.rty   = bus.cyc & bus.stb & rty_arm & (rty_hits == rty_base) & (bus.adr == rty_adr) & ~bus.err;
      bus.ack   = bus.cyc & bus.stb & slave_en & ~bus.err & ~bus.rty;
      bus.dat_r = wr_valid[widx] ? wmem[widx] : 32'hA000_0000 + 32'(widx);
   end

   always @(posedge clk) begin
      if (bus.ack && bus.we) begin
         wmem[widx]     <= bus.dat_w;
         wr_valid[widx] <= 1'b1;
      end
      if (bus.rty) rty_hits <= rty_hits + 1;
   end

   // Monitor: sampled mid-cycle.
   int          cyc_no = 0;
   int          rd_cnt = 0, wr_hs = 0, beat_cnt = 0, done_cnt = 0, err_hits = 0, wait_cnt = 0;
   logic [31:0] rd_dat   [0:255];
   logic [31:0] beat_adr [0:255];
   logic [2:0]  beat_cti [0:255];
   int          beat_cyc [0:255];
   int          rty_cyc = -10, err_cyc = -10, done_cyc = -10;
   logic        done_err = 1'b0, cyc_after_rty = 1'b1;

   always @(negedge clk) begin
      cyc_no = cyc_no + 1;
      if (rdat_valid === 1'b1 && rd_cnt < 256) begin rd_dat[rd_cnt] = rdat; rd_cnt = rd_cnt + 1; end
      if (wdat_ready === 1'b1 && wdat_valid === 1'b1) wr_hs = wr_hs + 1;
      if (bus.ack === 1'b1 && beat_cnt < 256) begin
         beat_adr[beat_cnt] = bus.adr;
         beat_cti[beat_cnt] = bus.cti;
         beat_cyc[beat_cnt] = cyc_no;
         beat_cnt = beat_cnt + 1;
      end
      if (bus.rty === 1'b1) rty_cyc = cyc_no;
      if (cyc_no == rty_cyc + 1) cyc_after_rty = bus.cyc;
      if (bus.err === 1'b1) begin err_hits = err_hits + 1; err_cyc = cyc_no; end
      if (done === 1'b1) begin done_cnt = done_cnt + 1; done_err = err; done_cyc = cyc_no; end
      if (bus.cyc === 1'b1 && bus.stb === 1'b0) wait_cnt = wait_cnt + 1;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len, input logic [3:0] sel);
      for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL cmd_ready_before_send: got %b expected 1", cmd_ready);
      end
      cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_sel = sel; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int  base;
      bit  seen;
      base = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != base) begin seen = 1'b1; break; end
         step();
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_done_timeout: got no done_o expected done_o within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_sel = '0;
      wdat = '0; wdat_valid = 1'b0;
      step(); step();
      vectors++;
      if ({cmd_ready, bus.cyc, bus.stb, bus.we, bus.cti, bus.bte, done, err, rdat_valid, wdat_ready} !== 14'h0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %h expected 0",
                  {cmd_ready, bus.cyc, bus.stb, bus.we, bus.cti, bus.bte, done, err, rdat_valid, wdat_ready});
      end
      vectors++;
      if ({bus.adr, bus.dat_w, bus.sel, rdat} !== 100'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 0", {bus.adr, bus.dat_w, bus.sel, rdat});
      end
      rst = 1'b0;
      step();
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_read_burst();
      logic [31:0] exp_adr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
      logic [2:0]  exp_cti [4] = '{CTI_INC, CTI_INC, CTI_INC, CTI_END};
      logic [31:0] exp_dat [4] = '{32'hA000_0040, 32'hA000_0041, 32'hA000_0042, 32'hA000_0043};
      int b0, r0;
      b0 = beat_cnt; r0 = rd_cnt;
      send_cmd(1'b0, 32'h0000_0103, 4'd3, 4'hF);
      vectors++;
      if ({bus.cyc, bus.stb, bus.adr} !== {2'b11, 32'h100}) begin
         miscompares++;
         $display("FAIL read_first_beat: got cyc/stb/adr %b%b/%h expected 11/00000100", bus.cyc, bus.stb, bus.adr);
      end
      wait_done(40, "read");
      vectors++;
      if (beat_cnt - b0 !== 4 || rd_cnt - r0 !== 4) begin
         miscompares++;
         $display("FAIL read_counts: got beats %0d rdat %0d expected 4 4", beat_cnt - b0, rd_cnt - r0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (beat_adr[b0+i] !== exp_adr[i] || beat_cti[b0+i] !== exp_cti[i] || rd_dat[r0+i] !== exp_dat[i]) begin
               miscompares++;
               $display("FAIL read_beat%0d: got adr %h cti %b dat %h expected %h %b %h", i,
                        beat_adr[b0+i], beat_cti[b0+i], rd_dat[r0+i], exp_adr[i], exp_cti[i], exp_dat[i]);
            end
         end
         vectors++;
         if (beat_cyc[b0+3] - beat_cyc[b0] !== 3 || done_cyc - beat_cyc[b0+3] !== 1 || done_err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_timing: got span %0d done_lag %0d err %b expected 3 1 0",
                     beat_cyc[b0+3] - beat_cyc[b0], done_cyc - beat_cyc[b0+3], done_err);
         end
      end
      vectors++;
      if (cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL read_ready_in_end: got %b expected 0", cmd_ready);
      end
      step();
      vectors++;
      if (cmd_ready !== 1'b1 || bus.cyc !== 1'b0) begin
         miscompares++;
         $display("FAIL read_idle_after: got ready %b cyc %b expected 1 0", cmd_ready, bus.cyc);
      end
   endtask

   task automatic test_write_gap();
      int  b0, h0, w0, words, gap;
      int  d0;
      logic hs;
      b0 = beat_cnt; h0 = wr_hs; w0 = wait_cnt; d0 = done_cnt;
      words = 0; gap = 0;
      wdat = 32'hDEAD_BEEF; wdat_valid = 1'b1;
      send_cmd(1'b1, 32'h200, 4'd1, 4'hF);
      for (int i = 0; i < 40 && done_cnt == d0; i++) begin
         hs = wdat_ready & wdat_valid;
         step();
         if (hs) begin
            words++;
            wdat_valid = 1'b0;
            if (words == 1) gap = 3;
         end else if (gap > 0) begin
            gap--;
            if (gap == 0) begin wdat = 32'h1234_5678; wdat_valid = 1'b1; end
         end
      end
      wdat_valid = 1'b0;
      vectors++;
      if (done_cnt - d0 !== 1 || done_err !== 1'b0) begin
         miscompares++;
         $display("FAIL write_done: got done %0d err %b expected 1 0", done_cnt - d0, done_err);
      end
      vectors++;
      if (wr_hs - h0 !== 2 || wait_cnt - w0 !== 4 || beat_cnt - b0 !== 2) begin
         miscompares++;
         $display("FAIL write_counts: got hs %0d waits %0d beats %0d expected 2 4 2",
                  wr_hs - h0, wait_cnt - w0, beat_cnt - b0);
      end else begin
         vectors++;
         if ({beat_adr[b0], beat_cti[b0], beat_adr[b0+1], beat_cti[b0+1]} !== {32'h200, CTI_INC, 32'h204, CTI_END}) begin
            miscompares++;
            $display("FAIL write_beats: got %h/%b %h/%b expected 00000200/010 00000204/111",
                     beat_adr[b0], beat_cti[b0], beat_adr[b0+1], beat_cti[b0+1]);
         end
      end
      vectors++;
      if (wmem[10'h080] !== 32'hDEAD_BEEF || wmem[10'h081] !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL write_mem: got %h %h expected deadbeef 12345678", wmem[10'h080], wmem[10'h081]);
      end
   endtask

   task automatic test_retry();
      logic [31:0] exp_adr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
      logic [2:0]  exp_cti [4] = '{CTI_INC, CTI_INC, CTI_INC, CTI_END};
      int b0, r0, h0;
      b0 = beat_cnt; r0 = rd_cnt; h0 = rty_hits;
      rty_base = rty_hits; rty_adr = 32'h108; rty_arm = 1'b1;
      send_cmd(1'b0, 32'h100, 4'd3, 4'hF);
      wait_done(40, "retry");
      rty_arm = 1'b0;
      vectors++;
      if (rty_hits - h0 !== 1 || beat_cnt - b0 !== 4 || rd_cnt - r0 !== 4 || done_err !== 1'b0) begin
         miscompares++;
         $display("FAIL retry_counts: got rty %0d beats %0d rdat %0d err %b expected 1 4 4 0",
                  rty_hits - h0, beat_cnt - b0, rd_cnt - r0, done_err);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (beat_adr[b0+i] !== exp_adr[i] || beat_cti[b0+i] !== exp_cti[i]) begin
               miscompares++;
               $display("FAIL retry_beat%0d: got %h/%b expected %h/%b", i,
                        beat_adr[b0+i], beat_cti[b0+i], exp_adr[i], exp_cti[i]);
            end
         end
         vectors++;
         if (cyc_after_rty !== 1'b0 || beat_cyc[b0+2] - rty_cyc !== 2) begin
            miscompares++;
            $display("FAIL retry_gap: got cyc %b reissue_lag %0d expected 0 2",
                     cyc_after_rty, beat_cyc[b0+2] - rty_cyc);
         end
      end
   endtask

   task automatic test_error();
      int b0, r0, e0;
      b0 = beat_cnt; r0 = rd_cnt; e0 = err_hits;
      err_adr = 32'h304; err_arm = 1'b1;
      send_cmd(1'b0, 32'h300, 4'd3, 4'hF);
      wait_done(40, "error");
      vectors++;
      if (done_err !== 1'b1 || bus.cyc !== 1'b0 || done_cyc - err_cyc !== 1) begin
         miscompares++;
         $display("FAIL error_end: got err %b cyc %b done_lag %0d expected 1 0 1",
                  done_err, bus.cyc, done_cyc - err_cyc);
      end
      err_arm = 1'b0;
      vectors++;
      if (rd_cnt - r0 !== 1 || beat_cnt - b0 !== 1 || err_hits - e0 !== 1 || rd_dat[r0] !== 32'hA000_00C0) begin
         miscompares++;
         $display("FAIL error_counts: got rdat %0d beats %0d errs %0d dat %h expected 1 1 1 a00000c0",
                  rd_cnt - r0, beat_cnt - b0, err_hits - e0, rd_dat[r0]);
      end
      step();
   endtask

   task automatic test_watchdog();
      int n, d0;
      d0 = done_cnt;
      slave_en = 1'b0;
      send_cmd(1'b0, 32'h400, 4'd0, 4'hF);
`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.cyc !== 1'b1) break;
         if (bus.stb === 1'b1) n++;
         step();
      end
      vectors++;
      if (n !== 16 || done !== 1'b1 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL watchdog_abort: got stb_cycles %0d done %b err %b expected 16 1 1", n, done, err);
      end
      slave_en = 1'b1;
      step();
`else
      n = 1;
      for (int i = 1; i < 100; i++) begin step(); n++; end
      vectors++;
      if (bus.cyc !== 1'b1 || bus.stb !== 1'b1 || done_cnt !== d0) begin
         miscompares++;
         $display("FAIL watchdog_hold: got cyc %b stb %b dones %0d at cycle %0d expected 1 1 0",
                  bus.cyc, bus.stb, done_cnt - d0, n);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      slave_en = 1'b1;
      step();
`endif
   endtask

   task automatic test_reset_mid_burst();
      int r0, d0;
      bit hit;
      r0 = rd_cnt; d0 = done_cnt; hit = 1'b0;
      send_cmd(1'b0, 32'h100, 4'd7, 4'hF);
      for (int i = 0; i < 20; i++) begin
         if (bus.ack === 1'b1 && bus.adr === 32'h108) begin hit = 1'b1; break; end
         step();
      end
      vectors++;
      if (!hit) begin
         miscompares++;
         $display("FAIL rst_mid_reach_beat2: got no beat at 00000108 expected one");
      end
      rst = 1'b1;
      step();
      vectors++;
      if ({cmd_ready, bus.cyc, bus.stb, bus.we, bus.cti, done, err, rdat_valid, wdat_ready, bus.adr, bus.sel, rdat} !== 79'h0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got %h expected 0",
                  {cmd_ready, bus.cyc, bus.stb, bus.we, bus.cti, done, err, rdat_valid, wdat_ready, bus.adr, bus.sel, rdat});
      end
      rst = 1'b0;
      step();
      for (int i = 0; i < 5; i++) step();
      vectors++;
      if (done_cnt !== d0 || rd_cnt - r0 !== 2 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_after: got dones %0d rdat %0d ready %b expected 0 2 1",
                  done_cnt - d0, rd_cnt - r0, cmd_ready);
      end
      r0 = rd_cnt;
      send_cmd(1'b0, 32'h500, 4'd1, 4'hF);
      wait_done(40, "rst_mid_new");
      vectors++;
      if (done_err !== 1'b0 || rd_cnt - r0 !== 2 || rd_dat[r0] !== 32'hA000_0140 || rd_dat[r0+1] !== 32'hA000_0141) begin
         miscompares++;
         $display("FAIL rst_mid_new_cmd: got err %b rdat %0d dat %h %h expected 0 2 a0000140 a0000141",
                  done_err, rd_cnt - r0, rd_dat[r0], rd_dat[r0+1]);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int r0;
      r0 = rd_cnt;
      send_cmd(1'b0, 32'h600, 4'd0, 4'hF);
      wait_done(20, "b2b_first");
      cmd_we = 1'b0; cmd_adr = 32'h604; cmd_len = 4'd0; cmd_sel = 4'hF; cmd_valid = 1'b1;
      step();
      vectors++;
      if (bus.cyc !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_idle_gap: got cyc %b ready %b expected 0 1", bus.cyc, cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      vectors++;
      if ({bus.cyc, bus.stb, bus.adr, bus.cti} !== {2'b11, 32'h604, CTI_END}) begin
         miscompares++;
         $display("FAIL b2b_second_issue: got cyc/stb %b%b adr %h cti %b expected 11 00000604 111",
                  bus.cyc, bus.stb, bus.adr, bus.cti);
      end
      wait_done(20, "b2b_second");
      vectors++;
      if (done_err !== 1'b0 || rd_cnt - r0 !== 2 || rd_dat[r0] !== 32'hA000_0180 || rd_dat[r0+1] !== 32'hA000_0181) begin
         miscompares++;
         $display("FAIL b2b_data: got err %b rdat %0d dat %h %h expected 0 2 a0000180 a0000181",
                  done_err, rd_cnt - r0, rd_dat[r0], rd_dat[r0+1]);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_write_gap();
      test_retry();
      test_error();
      test_watchdog();
      test_reset_mid_burst();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
